// File: rtl/hj_pkg.sv
// hj_pkg: grade encodings, default timing windows/points and FSM state type for hit_judge
package hj_pkg;
    typedef enum logic [1:0] {
        G_MISS    = 2'd0,
        G_OK      = 2'd1,
        G_GOOD    = 2'd2,
        G_PERFECT = 2'd3
    } grade_t;
    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;
    localparam int DEF_TARGET_Y    = 400;
    localparam int DEF_WIN_PERFECT = 10;
    localparam int DEF_WIN_GOOD    = 50;
    localparam int DEF_WIN_OK      = 80;
    localparam int DEF_PTS_PERFECT = 500;
    localparam int DEF_PTS_GOOD    = 300;
    localparam int DEF_PTS_OK      = 100;
endpackage

// File: rtl/hj_grade.sv
// hj_grade: combinational distance-to-target grading of one arrow y into grade and base points
module hj_grade
    import hj_pkg::*;
#(
    parameter int Y_W         = 10,
    parameter int SCORE_W     = 20,
    parameter int TARGET_Y    = DEF_TARGET_Y,
    parameter int WIN_PERFECT = DEF_WIN_PERFECT,
    parameter int WIN_GOOD    = DEF_WIN_GOOD,
    parameter int WIN_OK      = DEF_WIN_OK,
    parameter int PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int PTS_GOOD    = DEF_PTS_GOOD,
    parameter int PTS_OK      = DEF_PTS_OK
) (
    input  logic [Y_W-1:0]     y,
    output grade_t             grade,
    output logic [SCORE_W-1:0] base
);
    logic signed [Y_W+1:0] diff;
    logic [Y_W+1:0]        mag;
    assign diff  = $signed((Y_W+2)'(TARGET_Y)) - $signed({2'b00, y});
    assign mag   = diff[Y_W+1] ? -diff : diff;
    assign grade = (mag < (Y_W+2)'(WIN_PERFECT)) ? G_PERFECT :
                   (mag < (Y_W+2)'(WIN_GOOD))    ? G_GOOD    :
                   (mag < (Y_W+2)'(WIN_OK))      ? G_OK      : G_MISS;
    assign base  = (grade == G_PERFECT) ? SCORE_W'(PTS_PERFECT) :
                   (grade == G_GOOD)    ? SCORE_W'(PTS_GOOD)    :
                   (grade == G_OK)      ? SCORE_W'(PTS_OK)      : '0;
endmodule

// File: rtl/hit_judge.sv
// hit_judge: per-lane press capture, lowest-lane-first judging, combo multiplier and saturating score
module hit_judge
    import hj_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int Y_W         = 10,
    parameter int SCORE_W     = 20,
    parameter int TARGET_Y    = DEF_TARGET_Y,
    parameter int WIN_PERFECT = DEF_WIN_PERFECT,
    parameter int WIN_GOOD    = DEF_WIN_GOOD,
    parameter int WIN_OK      = DEF_WIN_OK,
    parameter int PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int PTS_GOOD    = DEF_PTS_GOOD,
    parameter int PTS_OK      = DEF_PTS_OK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [LANES-1:0]         btn_valid,
    input  logic [LANES*Y_W-1:0]     y_coord,
    output logic                     hit_valid,
    output logic [$clog2(LANES)-1:0] hit_lane,
    output logic [1:0]               hit_grade,
    output logic [SCORE_W-1:0]       hit_pts,
    output logic [LANES-1:0]         arrow_flag,
    output logic [15:0]              combo,
    output logic [SCORE_W-1:0]       score,
    output logic                     busy
);
    localparam int LW = $clog2(LANES);
    state_t                    state_q, state_d;
    logic [LANES-1:0]          btn_q, btn_d, pending_q, pending_d, rise, req, pick;
    logic [LANES-1:0][Y_W-1:0] y_q, y_d;
    logic [LW-1:0]             sel_lane;
    logic [Y_W-1:0]            sel_y;
    logic                      play, judge;
    grade_t                    grade;
    logic [SCORE_W-1:0]        base, pts, score_q, score_d, hit_pts_q, hit_pts_d;
    logic [SCORE_W+1:0]        pts_wide;
    logic [SCORE_W:0]          sum;
    logic [15:0]               combo_q, combo_d;
    logic                      hit_valid_q, hit_valid_d;
    logic [LW-1:0]             hit_lane_q, hit_lane_d;
    grade_t                    hit_grade_q, hit_grade_d;
    logic [LANES-1:0]          arrow_q, arrow_d;

    assign play  = state_q == S_PLAY;
    assign rise  = btn_valid & ~btn_q;
    assign req   = play ? (pending_q | rise) : '0;
    assign judge = play && !start && !stop && |req;

    // A lane rising this very cycle is judged on its live y, which also covers the overwrite case.
    always_comb begin
        sel_lane = '0;
        sel_y    = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (req[l]) begin
                sel_lane = LW'(l);
                sel_y    = rise[l] ? y_coord[l*Y_W +: Y_W] : y_q[l];
            end
        end
    end

    hj_grade #(
        .Y_W(Y_W), .SCORE_W(SCORE_W), .TARGET_Y(TARGET_Y),
        .WIN_PERFECT(WIN_PERFECT), .WIN_GOOD(WIN_GOOD), .WIN_OK(WIN_OK),
        .PTS_PERFECT(PTS_PERFECT), .PTS_GOOD(PTS_GOOD), .PTS_OK(PTS_OK)
    ) u_grade (
        .y    (sel_y),
        .grade(grade),
        .base (base)
    );

    assign pts_wide = {2'b00, base} << ((combo_q < 16'd10) ? 2'd0 : (combo_q < 16'd30) ? 2'd1 : 2'd2);
    assign pts      = |pts_wide[SCORE_W+1:SCORE_W] ? '1 : pts_wide[SCORE_W-1:0];
    assign sum      = {1'b0, score_q} + {1'b0, pts};
    assign pick     = judge ? (LANES'(1) << sel_lane) : '0;

    always_comb begin
        state_d     = state_q;
        btn_d       = btn_valid;
        pending_d   = req & ~pick;
        for (int l = 0; l < LANES; l++) y_d[l] = (play && rise[l]) ? y_coord[l*Y_W +: Y_W] : y_q[l];
        score_d     = judge ? (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]) : score_q;
        combo_d     = !judge ? combo_q : (grade == G_MISS) ? '0 : (&combo_q) ? combo_q : combo_q + 16'd1;
        hit_valid_d = judge;
        hit_lane_d  = judge ? sel_lane : '0;
        hit_grade_d = judge ? grade : G_MISS;
        hit_pts_d   = judge ? pts : '0;
        arrow_d     = pick;
        if (play && stop) begin
            state_d   = S_IDLE;
            pending_d = '0;
        end else if (start) begin
            state_d   = S_PLAY;
            pending_d = '0;
            score_d   = '0;
            combo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            btn_q       <= '0;
            pending_q   <= '0;
            y_q         <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            hit_valid_q <= 1'b0;
            hit_lane_q  <= '0;
            hit_grade_q <= G_MISS;
            hit_pts_q   <= '0;
            arrow_q     <= '0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            pending_q   <= pending_d;
            y_q         <= y_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            hit_valid_q <= hit_valid_d;
            hit_lane_q  <= hit_lane_d;
            hit_grade_q <= hit_grade_d;
            hit_pts_q   <= hit_pts_d;
            arrow_q     <= arrow_d;
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_lane   = hit_lane_q;
    assign hit_grade  = hit_grade_q;
    assign hit_pts    = hit_pts_q;
    assign arrow_flag = arrow_q;
    assign combo      = combo_q;
    assign score      = score_q;
    assign busy       = play;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed scenario tasks for hit_judge, default instance plus a SCORE_W=10 instance
module tb_hit_judge;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [3:0]  btn_valid;
    logic [39:0] y_coord;
    logic        hit_valid, busy, s_hit_valid, s_busy;
    logic [1:0]  hit_lane, hit_grade, s_hit_lane, s_hit_grade;
    logic [19:0] hit_pts, score;
    logic [9:0]  s_hit_pts, s_score;
    logic [3:0]  arrow_flag, s_arrow_flag;
    logic [15:0] combo, s_combo;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    hit_judge dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .btn_valid(btn_valid), .y_coord(y_coord),
        .hit_valid(hit_valid), .hit_lane(hit_lane), .hit_grade(hit_grade), .hit_pts(hit_pts),
        .arrow_flag(arrow_flag), .combo(combo), .score(score), .busy(busy)
    );

    hit_judge #(.SCORE_W(10)) u_small (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .btn_valid(btn_valid), .y_coord(y_coord),
        .hit_valid(s_hit_valid), .hit_lane(s_hit_lane), .hit_grade(s_hit_grade), .hit_pts(s_hit_pts),
        .arrow_flag(s_arrow_flag), .combo(s_combo), .score(s_score), .busy(s_busy)
    );

    function automatic logic [28:0] hv();
        return {hit_valid, hit_lane, hit_grade, hit_pts, arrow_flag};
    endfunction

    function automatic logic [28:0] ex(input logic v, input logic [1:0] l, input logic [1:0] g,
                                       input logic [19:0] p, input logic [3:0] a);
        return {v, l, g, p, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int lane, input logic [9:0] y);
        btn_valid[lane] = 1'b1;
        y_coord[lane*10 +: 10] = y;
        step();
    endtask

    task automatic release_all();
        btn_valid = '0;
        step();
    endtask

    task automatic begin_song();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (hv() !== 29'd0) begin n_err++; $display("FAIL reset_hit got %h exp %h", hv(), 29'd0); end
        n_cmp++; if ({score, combo, busy} !== 37'd0) begin n_err++; $display("FAIL reset_state got %h exp 0", {score, combo, busy}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_perfect();
        begin_song();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", busy); end
        press(0, 10'd400);
        n_cmp++; if (hv() !== ex(1'b1, 2'd0, 2'd3, 20'd500, 4'b0001)) begin n_err++; $display("FAIL perfect_hit got %h exp %h", hv(), ex(1'b1, 2'd0, 2'd3, 20'd500, 4'b0001)); end
        n_cmp++; if ({score, combo} !== {20'd500, 16'd1}) begin n_err++; $display("FAIL perfect_score got %0d/%0d exp 500/1", score, combo); end
        release_all();
        n_cmp++; if (hit_valid !== 1'b0) begin n_err++; $display("FAIL perfect_one_cycle got %b exp 0", hit_valid); end
    endtask

    task automatic test_two_lanes();
        y_coord[10 +: 10] = 10'd360;
        y_coord[20 +: 10] = 10'd330;
        btn_valid = 4'b0110;
        step();
        n_cmp++; if (hv() !== ex(1'b1, 2'd1, 2'd2, 20'd300, 4'b0010)) begin n_err++; $display("FAIL lane1_good got %h exp %h", hv(), ex(1'b1, 2'd1, 2'd2, 20'd300, 4'b0010)); end
        step();
        n_cmp++; if (hv() !== ex(1'b1, 2'd2, 2'd1, 20'd100, 4'b0100)) begin n_err++; $display("FAIL lane2_ok got %h exp %h", hv(), ex(1'b1, 2'd2, 2'd1, 20'd100, 4'b0100)); end
        n_cmp++; if ({score, combo} !== {20'd900, 16'd3}) begin n_err++; $display("FAIL two_lane_score got %0d/%0d exp 900/3", score, combo); end
        step();
        n_cmp++; if (hit_valid !== 1'b0) begin n_err++; $display("FAIL two_lane_drain got %b exp 0", hit_valid); end
        release_all();
    endtask

    task automatic test_windows();
        logic [9:0]  ys[6] = '{10'd390, 10'd410, 10'd391, 10'd350, 10'd321, 10'd320};
        logic [1:0]  gs[6] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0};
        logic [19:0] ps[6] = '{20'd300, 20'd300, 20'd500, 20'd100, 20'd100, 20'd0};
        begin_song();
        for (int i = 0; i < 6; i++) begin
            press(0, ys[i]);
            n_cmp++; if (hv() !== ex(1'b1, 2'd0, gs[i], ps[i], 4'b0001)) begin n_err++; $display("FAIL window_y%0d got %h exp %h", ys[i], hv(), ex(1'b1, 2'd0, gs[i], ps[i], 4'b0001)); end
            release_all();
        end
        n_cmp++; if ({score, combo} !== {20'd1300, 16'd0}) begin n_err++; $display("FAIL window_score got %0d/%0d exp 1300/0", score, combo); end
    endtask

    task automatic test_multiplier();
        begin_song();
        for (int i = 0; i < 10; i++) begin press(0, 10'd400); release_all(); end
        press(0, 10'd400);
        n_cmp++; if (hit_pts !== 20'd1000) begin n_err++; $display("FAIL mult_x2 got %0d exp 1000", hit_pts); end
        n_cmp++; if ({score, combo} !== {20'd6000, 16'd11}) begin n_err++; $display("FAIL mult_x2_score got %0d/%0d exp 6000/11", score, combo); end
        release_all();
        for (int i = 0; i < 19; i++) begin press(0, 10'd400); release_all(); end
        press(0, 10'd400);
        n_cmp++; if (hit_pts !== 20'd2000) begin n_err++; $display("FAIL mult_x4 got %0d exp 2000", hit_pts); end
        n_cmp++; if ({score, combo} !== {20'd27000, 16'd31}) begin n_err++; $display("FAIL mult_x4_score got %0d/%0d exp 27000/31", score, combo); end
        release_all();
        press(0, 10'd0);
        n_cmp++; if (hv() !== ex(1'b1, 2'd0, 2'd0, 20'd0, 4'b0001)) begin n_err++; $display("FAIL miss_hit got %h exp %h", hv(), ex(1'b1, 2'd0, 2'd0, 20'd0, 4'b0001)); end
        n_cmp++; if ({score, combo} !== {20'd27000, 16'd0}) begin n_err++; $display("FAIL miss_score got %0d/%0d exp 27000/0", score, combo); end
        release_all();
    endtask

    task automatic test_saturation();
        begin_song();
        for (int i = 0; i < 2; i++) begin press(0, 10'd400); release_all(); end
        n_cmp++; if (s_score !== 10'd1000) begin n_err++; $display("FAIL sat_pre got %0d exp 1000", s_score); end
        press(0, 10'd400);
        n_cmp++; if ({s_hit_pts, s_score} !== {10'd500, 10'd1023}) begin n_err++; $display("FAIL sat_score got %0d/%0d exp 500/1023", s_hit_pts, s_score); end
        release_all();
    endtask

    task automatic test_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++; if ({busy, hit_valid} !== 2'b00) begin n_err++; $display("FAIL stop_busy got %b exp 00", {busy, hit_valid}); end
        press(3, 10'd400);
        n_cmp++; if (hv() !== 29'd0) begin n_err++; $display("FAIL idle_press got %h exp 0", hv()); end
        n_cmp++; if ({score, combo} !== {20'd1500, 16'd3}) begin n_err++; $display("FAIL idle_hold got %0d/%0d exp 1500/3", score, combo); end
        release_all();
        begin_song();
        n_cmp++; if ({busy, score, combo} !== 37'h1_0000_0000_0 >> 0 && {busy, score, combo} !== {1'b1, 36'd0}) begin n_err++; $display("FAIL restart got %h exp %h", {busy, score, combo}, {1'b1, 36'd0}); end
        y_coord[0 +: 10] = 10'd400;
        y_coord[10 +: 10] = 10'd400;
        btn_valid = 4'b0011;
        step();
        n_cmp++; if (hv() !== ex(1'b1, 2'd0, 2'd3, 20'd500, 4'b0001)) begin n_err++; $display("FAIL pend_lane0 got %h exp %h", hv(), ex(1'b1, 2'd0, 2'd3, 20'd500, 4'b0001)); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++; if ({busy, hv()} !== 30'd0) begin n_err++; $display("FAIL stop_pending got %h exp 0", {busy, hv()}); end
        step();
        n_cmp++; if (hv() !== 29'd0) begin n_err++; $display("FAIL stop_discard got %h exp 0", hv()); end
        release_all();
    endtask

    task automatic test_reset_mid();
        begin_song();
        y_coord[0 +: 10] = 10'd400;
        y_coord[10 +: 10] = 10'd400;
        btn_valid = 4'b0011;
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (hv() !== 29'd0) begin n_err++; $display("FAIL rst_mid_hit got %h exp 0", hv()); end
        n_cmp++; if ({busy, score, combo} !== 37'd0) begin n_err++; $display("FAIL rst_mid_state got %h exp 0", {busy, score, combo}); end
        rst = 1'b0;
        step();
        n_cmp++; if ({busy, hv()} !== 30'd0) begin n_err++; $display("FAIL rst_mid_after got %h exp 0", {busy, hv()}); end
        release_all();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        btn_valid = '0;
        y_coord = '0;
        test_reset();
        test_perfect();
        test_two_lanes();
        test_windows();
        test_multiplier();
        test_saturation();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
